// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction-memory request/response bus
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetch unit drives the request side and receives the response.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Instruction memory answers requests.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC/IR fetch unit with immediate decode
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_en,
  input  logic                pc_load,
  input  logic [31:0]         pc_wdata,
  instr_fetch_if.master       imem,
  output logic [31:0]         pc,
  output logic [31:0]         ir,
  output logic [6:0]          opcode,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [31:0]         imm,
  output logic                fetch_busy,
  output logic                fetch_done
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, REQ} state_t;

  state_t state;
  state_t state_next;
  logic   capture;
  logic   load_pc;

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs; ack only matters while requesting.
  always_comb begin
    state_next    = state;
    imem.imem_req = 1'b0;
    fetch_busy    = 1'b0;
    capture       = 1'b0;
    load_pc       = 1'b0;
    case (state)
      IDLE: begin
        load_pc = pc_load;
        if (fetch_en) begin
          state_next = REQ;
        end
      end
      REQ: begin
        imem.imem_req = 1'b1;
        fetch_busy    = 1'b1;
        if (imem.imem_ack) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem.imem_addr = pc;

  // PC/IR update: loads only in IDLE, so the request address stays fixed in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      ir         <= NOP;
      fetch_done <= 1'b0;
    end else begin
      fetch_done <= capture;
      if (capture) begin
        ir <= imem.imem_rdata;
        pc <= pc + 32'd4;
      end else if (load_pc) begin
        pc <= pc_wdata & ~32'h0000_0003;
      end
    end
  end

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rd     = ir[11:7];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

  // Immediate for I-type ALU/load, S-type store and LUI; everything else reads zero.
  always_comb begin
    imm = 32'h0000_0000;
    case (ir[6:0])
      7'b0010011,
      7'b0000011: imm = {{20{ir[31]}}, ir[31:20]};
      7'b0100011: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      7'b0110111: imm = {ir[31:12], 12'b0};
      default:    imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;
  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        pc_load;
  logic [31:0] pc_wdata;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        fetch_busy;
  logic        fetch_done;

  int checks;
  int errors;

  instr_fetch_if imem ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_en   (fetch_en),
    .pc_load    (pc_load),
    .pc_wdata   (pc_wdata),
    .imem       (imem),
    .pc         (pc),
    .ir         (ir),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    fetch_en        = 1'b0;
    pc_load         = 1'b0;
    pc_wdata        = 32'h0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;
    tick();
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_req", {31'b0, imem.imem_req}, 32'h0);
    chk("rst_done", {31'b0, fetch_done}, 32'h0);
    chk("rst_busy", {31'b0, fetch_busy}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_req", {31'b0, imem.imem_req}, 32'h0);

    // zero-wait fetch of addi x1,x0,5
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("f1_req", {31'b0, imem.imem_req}, 32'h1);
    chk("f1_addr", imem.imem_addr, 32'h0);
    chk("f1_busy", {31'b0, fetch_busy}, 32'h1);
    chk("f1_done_early", {31'b0, fetch_done}, 32'h0);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h0050_0093;
    tick();
    imem.imem_ack = 1'b0;
    chk("f1_ir", ir, 32'h0050_0093);
    chk("f1_pc", pc, 32'h4);
    chk("f1_rd", {27'b0, rd}, 32'h1);
    chk("f1_imm", imm, 32'h5);
    chk("f1_opcode", {25'b0, opcode}, 32'h13);
    chk("f1_done", {31'b0, fetch_done}, 32'h1);
    chk("f1_busy_off", {31'b0, fetch_busy}, 32'h0);
    tick();
    chk("f1_done_pulse", {31'b0, fetch_done}, 32'h0);

    // three wait cycles, addi x1,x0,-1
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("f2_wait_req", {31'b0, imem.imem_req}, 32'h1);
      chk("f2_wait_addr", imem.imem_addr, 32'h4);
      chk("f2_wait_done", {31'b0, fetch_done}, 32'h0);
      chk("f2_wait_pc", pc, 32'h4);
      tick();
    end
    chk("f2_req4", {31'b0, imem.imem_req}, 32'h1);
    chk("f2_addr4", imem.imem_addr, 32'h4);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hFFF0_0093;
    tick();
    imem.imem_ack = 1'b0;
    chk("f2_done", {31'b0, fetch_done}, 32'h1);
    chk("f2_pc", pc, 32'h8);
    chk("f2_imm", imm, 32'hFFFF_FFFF);
    tick();
    chk("f2_done_pulse", {31'b0, fetch_done}, 32'h0);

    // ack while idle is ignored
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    imem.imem_ack = 1'b0;
    chk("idle_ack_ir", ir, 32'hFFF0_0093);
    chk("idle_ack_pc", pc, 32'h8);
    chk("idle_ack_req", {31'b0, imem.imem_req}, 32'h0);
    chk("idle_ack_done", {31'b0, fetch_done}, 32'h0);

    // pc_load with fetch_en; pc_load in REQ ignored; lw immediate
    pc_load  = 1'b1;
    pc_wdata = 32'h0000_0103;
    fetch_en = 1'b1;
    tick();
    pc_load  = 1'b0;
    fetch_en = 1'b0;
    chk("ld_pc", pc, 32'h0000_0100);
    chk("ld_addr", imem.imem_addr, 32'h0000_0100);
    chk("ld_req", {31'b0, imem.imem_req}, 32'h1);
    pc_load  = 1'b1;
    pc_wdata = 32'h0000_0500;
    tick();
    pc_load = 1'b0;
    chk("ld_req_ignore_pc", pc, 32'h0000_0100);
    chk("ld_req_ignore_addr", imem.imem_addr, 32'h0000_0100);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h8000_2003;
    tick();
    imem.imem_ack = 1'b0;
    chk("ld_pc_after", pc, 32'h0000_0104);
    chk("ld_imm", imm, 32'hFFFF_F800);
    chk("ld_funct3", {29'b0, funct3}, 32'h2);

    // wrap at top of address space; sw immediate
    pc_load  = 1'b1;
    pc_wdata = 32'hFFFF_FFFC;
    fetch_en = 1'b1;
    tick();
    pc_load  = 1'b0;
    fetch_en = 1'b0;
    chk("wr_addr", imem.imem_addr, 32'hFFFF_FFFC);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hFE11_2E23;
    tick();
    imem.imem_ack = 1'b0;
    chk("wr_pc", pc, 32'h0);
    chk("wr_imm", imm, 32'hFFFF_FFFC);
    chk("wr_opcode", {25'b0, opcode}, 32'h23);
    chk("wr_funct7", {25'b0, funct7}, 32'h7F);
    chk("wr_rs1", {27'b0, rs1}, 32'h2);
    chk("wr_rs2", {27'b0, rs2}, 32'h1);

    // fetch_en held through REQ; lui immediate
    fetch_en = 1'b1;
    tick();
    chk("lu_busy0", {31'b0, fetch_busy}, 32'h1);
    tick();
    chk("lu_busy1", {31'b0, fetch_busy}, 32'h1);
    chk("lu_addr1", imem.imem_addr, 32'h0);
    tick();
    chk("lu_addr2", imem.imem_addr, 32'h0);
    chk("lu_done_early", {31'b0, fetch_done}, 32'h0);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h1234_50B7;
    fetch_en        = 1'b0;
    tick();
    imem.imem_ack = 1'b0;
    chk("lu_done", {31'b0, fetch_done}, 32'h1);
    chk("lu_pc", pc, 32'h4);
    chk("lu_imm", imm, 32'h1234_5000);
    chk("lu_opcode", {25'b0, opcode}, 32'h37);
    chk("lu_rd", {27'b0, rd}, 32'h1);
    chk("lu_busy_off", {31'b0, fetch_busy}, 32'h0);
    tick();
    chk("lu_no_second_req", {31'b0, imem.imem_req}, 32'h0);
    chk("lu_done_pulse", {31'b0, fetch_done}, 32'h0);
    chk("lu_pc_hold", pc, 32'h4);

    // reset mid-REQ, late ack afterwards
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("rr_req", {31'b0, imem.imem_req}, 32'h1);
    chk("rr_addr", imem.imem_addr, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_async_pc", pc, 32'h0);
    chk("rr_async_ir", ir, 32'h0000_0013);
    chk("rr_async_req", {31'b0, imem.imem_req}, 32'h0);
    chk("rr_async_busy", {31'b0, fetch_busy}, 32'h0);
    tick();
    rst_n           = 1'b1;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'h0050_0093;
    tick();
    chk("rr_late_done0", {31'b0, fetch_done}, 32'h0);
    tick();
    imem.imem_ack = 1'b0;
    chk("rr_late_ir", ir, 32'h0000_0013);
    chk("rr_late_pc", pc, 32'h0);
    chk("rr_late_done1", {31'b0, fetch_done}, 32'h0);
    chk("rr_late_busy", {31'b0, fetch_busy}, 32'h0);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("rr_first_addr", imem.imem_addr, 32'h0);
    chk("rr_first_req", {31'b0, imem.imem_req}, 32'h1);
    imem.imem_ack = 1'b1;
    tick();
    imem.imem_ack = 1'b0;
    chk("rr_first_pc", pc, 32'h4);
    chk("rr_first_done", {31'b0, fetch_done}, 32'h1);
    chk("rr_first_ir", ir, 32'h0050_0093);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
